// File: rtl/uart_parity_engine.sv
// TX parity generator with run-time data length and four parity modes.
// Define PARITY_CHECK_EN to build the bit-serial RX parity checker; otherwise rx_done/rx_par_err are 0.
module uart_parity_engine #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             parity_enable,
  input  logic [1:0]       parity_mode,
  input  logic [3:0]       data_len,
  input  logic             Busy,
  input  logic [WIDTH-1:0] DATA,
  input  logic             Data_Valid,
  output logic [WIDTH-1:0] data_latched,
  output logic             parity,
  output logic             parity_valid,
  input  logic             rx_start,
  input  logic             rx_bit_valid,
  input  logic             rx_bit,
  output logic             rx_done,
  output logic             rx_par_err
);

  logic [3:0]       eff_len;
  logic [WIDTH-1:0] len_mask;
  logic             capture;

  function automatic logic mode_parity(input logic [1:0] mode, input logic xor_bits);
    logic p;
    case (mode)
      2'b00:   p = xor_bits;
      2'b01:   p = ~xor_bits;
      2'b10:   p = 1'b1;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  always_comb begin
    if (data_len < 4'd5) begin
      eff_len = 4'd5;
    end else if (32'(data_len) > WIDTH) begin
      eff_len = 4'(WIDTH);
    end else begin
      eff_len = data_len;
    end
  end

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      len_mask[i] = (i < int'(eff_len));
    end
  end

  assign capture = Data_Valid && !Busy;

  // A capture on the same edge as parity_enable clears parity_valid; the new parity lands next edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_latched <= '0;
      parity       <= 1'b0;
      parity_valid <= 1'b0;
    end else begin
      if (capture) begin
        data_latched <= DATA & len_mask;
        parity_valid <= 1'b0;
      end else if (parity_enable) begin
        parity_valid <= 1'b1;
      end
      if (parity_enable) begin
        parity <= mode_parity(parity_mode, ^data_latched);
      end
    end
  end

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {StIdle, StData, StPar} rx_state_e;

  rx_state_e rx_state;
  logic [3:0] rx_cnt;
  logic       rx_acc;
  logic       rx_last;

  // Data phase ends on the edge that samples the final data bit.
  always_comb begin
    if (rx_bit_valid) begin
      rx_last = ({1'b0, rx_cnt} + 5'd1) >= {1'b0, eff_len};
    end else begin
      rx_last = rx_cnt >= eff_len;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_state   <= StIdle;
      rx_cnt     <= 4'd0;
      rx_acc     <= 1'b0;
      rx_done    <= 1'b0;
      rx_par_err <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (rx_start) begin
        rx_state   <= StData;
        rx_cnt     <= 4'd0;
        rx_acc     <= 1'b0;
        rx_par_err <= 1'b0;
      end else begin
        case (rx_state)
          StData: begin
            if (rx_bit_valid) begin
              rx_acc <= rx_acc ^ rx_bit;
              rx_cnt <= rx_cnt + 4'd1;
            end
            if (rx_last) begin
              if (parity_enable) begin
                rx_state <= StPar;
              end else begin
                rx_state   <= StIdle;
                rx_done    <= 1'b1;
                rx_par_err <= 1'b0;
              end
            end
          end
          StPar: begin
            if (rx_bit_valid) begin
              rx_par_err <= rx_bit != mode_parity(parity_mode, rx_acc);
              rx_done    <= 1'b1;
              rx_state   <= StIdle;
            end
          end
          default: rx_state <= StIdle;
        endcase
      end
    end
  end
`else
  logic unused_rx;
  assign unused_rx  = ^{rx_start, rx_bit_valid, rx_bit};
  assign rx_done    = 1'b0;
  assign rx_par_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_parity_engine.sv
// Directed plus randomized bench for uart_parity_engine against a behavioural frame-level model.
module tb_uart_parity_engine;
  localparam int unsigned WIDTH = 9;

`ifdef PARITY_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RST;
  logic             parity_enable;
  logic [1:0]       parity_mode;
  logic [3:0]       data_len;
  logic             Busy;
  logic [WIDTH-1:0] DATA;
  logic             Data_Valid;
  logic [WIDTH-1:0] data_latched;
  logic             parity;
  logic             parity_valid;
  logic             rx_start;
  logic             rx_bit_valid;
  logic             rx_bit;
  logic             rx_done;
  logic             rx_par_err;

  int total = 0;
  int bad   = 0;

  uart_parity_engine #(.WIDTH(WIDTH)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .parity_enable(parity_enable),
    .parity_mode  (parity_mode),
    .data_len     (data_len),
    .Busy         (Busy),
    .DATA         (DATA),
    .Data_Valid   (Data_Valid),
    .data_latched (data_latched),
    .parity       (parity),
    .parity_valid (parity_valid),
    .rx_start     (rx_start),
    .rx_bit_valid (rx_bit_valid),
    .rx_bit       (rx_bit),
    .rx_done      (rx_done),
    .rx_par_err   (rx_par_err)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff(input logic [3:0] l);
    if (l < 4'd5) return 5;
    if (int'(l) > int'(WIDTH)) return int'(WIDTH);
    return int'(l);
  endfunction

  function automatic logic [WIDTH-1:0] masked(input logic [WIDTH-1:0] d, input logic [3:0] l);
    logic [15:0] m;
    m = (16'd1 << eff(l)) - 16'd1;
    return d & m[WIDTH-1:0];
  endfunction

  function automatic logic ref_par(input logic [WIDTH-1:0] v, input logic [1:0] mode);
    int ones;
    ones = $countones(v);
    if (mode == 2'd0) return (ones % 2) == 1;
    if (mode == 2'd1) return (ones % 2) == 0;
    return mode == 2'd2;
  endfunction

  // Capture one word with parity enabled and check data, then parity one cycle later.
  task automatic capture(input logic [WIDTH-1:0] d, input logic [3:0] l, input logic [1:0] m,
                         input string tag);
    DATA = d; data_len = l; parity_mode = m; parity_enable = 1'b1; Busy = 1'b0; Data_Valid = 1'b1;
    step();
    Data_Valid = 1'b0;
    chk({tag, "_lat"}, 16'(data_latched), 16'(masked(d, l)));
    chk({tag, "_pv0"}, 16'(parity_valid), 16'd0);
    step();
    chk({tag, "_par"}, 16'(parity), 16'(ref_par(masked(d, l), m)));
    chk({tag, "_pv1"}, 16'(parity_valid), 16'd1);
  endtask

  // Send a complete RX frame after rx_start and check the rx_done pulse and error flag.
  task automatic rx_frame(input logic [WIDTH-1:0] d, input logic [3:0] l, input logic [1:0] m,
                          input logic pe, input logic pbit, input string tag);
    logic exp_err;
    data_len = l; parity_mode = m; parity_enable = pe;
    rx_start = 1'b1;
    step();
    rx_start = 1'b0;
    for (int i = 0; i < eff(l); i++) begin
      rx_bit_valid = 1'b1;
      rx_bit = d[i];
      step();
    end
    if (pe) begin
      chk({tag, "_nodone"}, 16'(rx_done), 16'd0);
      rx_bit = pbit;
      step();
    end
    rx_bit_valid = 1'b0;
    exp_err = pe ? (pbit != ref_par(masked(d, l), m)) : 1'b0;
    chk({tag, "_done"}, 16'(rx_done), 16'(CHK));
    chk({tag, "_err"}, 16'(rx_par_err), 16'(CHK & exp_err));
    step();
    chk({tag, "_done_off"}, 16'(rx_done), 16'd0);
    chk({tag, "_err_hold"}, 16'(rx_par_err), 16'(CHK & exp_err));
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] lat;
    logic [3:0]       l;
    logic [1:0]       m;
    logic             b;

    RST = 1'b0; parity_enable = 1'b0; parity_mode = 2'd0; data_len = 4'd8; Busy = 1'b0;
    DATA = '0; Data_Valid = 1'b0; rx_start = 1'b0; rx_bit_valid = 1'b0; rx_bit = 1'b0;
    step(); step();
    chk("rst_lat", 16'(data_latched), 16'd0);
    chk("rst_par", 16'(parity), 16'd0);
    chk("rst_pv", 16'(parity_valid), 16'd0);
    chk("rst_done", 16'(rx_done), 16'd0);
    chk("rst_err", 16'(rx_par_err), 16'd0);
    RST = 1'b1;
    repeat (5) step();
    chk("idle_lat", 16'(data_latched), 16'd0);
    chk("idle_par", 16'(parity), 16'd0);
    chk("idle_pv", 16'(parity_valid), 16'd0);
    chk("idle_done", 16'(rx_done), 16'd0);

    // Directed TX cases
    capture(9'h1A5, 4'd8, 2'b00, "even_a5");
    chk("even_a5_lit", 16'(data_latched), 16'h0A5);
    chk("even_a5_plit", 16'(parity), 16'd0);
    capture(9'h1A5, 4'd8, 2'b01, "odd_a5");
    chk("odd_a5_plit", 16'(parity), 16'd1);
    capture(9'h1FF, 4'd5, 2'b00, "len5");
    chk("len5_lit", 16'(data_latched), 16'h01F);
    chk("len5_plit", 16'(parity), 16'd1);
    DATA = '0; Busy = 1'b1; Data_Valid = 1'b1;
    step();
    Data_Valid = 1'b0; Busy = 1'b0;
    chk("busy_ignored", 16'(data_latched), 16'h01F);
    capture(9'h0F0, 4'd8, 2'b10, "mark");
    capture(9'h0F1, 4'd8, 2'b11, "space");
    capture(9'h1FF, 4'd5, 2'b00, "pre_hold");
    DATA = 9'h003; data_len = 4'd8; parity_mode = 2'b00; parity_enable = 1'b0; Data_Valid = 1'b1;
    step();
    Data_Valid = 1'b0;
    chk("hold_lat", 16'(data_latched), 16'h003);
    step();
    chk("hold_par", 16'(parity), 16'd1);
    chk("hold_pv", 16'(parity_valid), 16'd0);
    parity_enable = 1'b1;
    step();
    chk("hold_par_new", 16'(parity), 16'd0);
    chk("hold_pv_new", 16'(parity_valid), 16'd1);

    // Back-to-back captures
    data_len = 4'd9; parity_mode = 2'b00; Data_Valid = 1'b1; DATA = 9'h001;
    step();
    DATA = 9'h003;
    step();
    Data_Valid = 1'b0;
    chk("b2b_lat", 16'(data_latched), 16'h003);
    chk("b2b_pv0", 16'(parity_valid), 16'd0);
    step();
    chk("b2b_pv1", 16'(parity_valid), 16'd1);
    chk("b2b_par", 16'(parity), 16'd0);

    // Random captures with random Busy and out-of-range lengths
    lat = data_latched;
    for (int k = 0; k < 30; k++) begin
      d = WIDTH'($urandom); l = 4'($urandom_range(0, 15)); m = 2'($urandom_range(0, 3));
      b = ($urandom_range(0, 3) == 0);
      if (b) begin
        DATA = d; data_len = l; Busy = 1'b1; Data_Valid = 1'b1;
        step();
        Data_Valid = 1'b0; Busy = 1'b0;
        chk("rnd_busy", 16'(data_latched), 16'(lat));
      end else begin
        capture(d, l, m, "rnd_cap");
        lat = masked(d, l);
      end
    end

    // Checker directed frames
    rx_frame(9'h0A5, 4'd8, 2'b00, 1'b1, 1'b0, "rx_good");
    rx_frame(9'h0A5, 4'd8, 2'b00, 1'b1, 1'b1, "rx_bad");
    rx_frame(9'h0A5, 4'd8, 2'b00, 1'b0, 1'b0, "rx_nopar");

    // Restart after 4 bits, with rx_start colliding with a valid bit
    data_len = 4'd8; parity_mode = 2'b00; parity_enable = 1'b1;
    rx_start = 1'b1;
    step();
    rx_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx_bit_valid = 1'b1; rx_bit = 1'b1;
      step();
    end
    rx_start = 1'b1; rx_bit = 1'b1;
    step();
    rx_start = 1'b0;
    chk("restart_nodone", 16'(rx_done), 16'd0);
    d = 9'h05A;
    for (int i = 0; i < 8; i++) begin
      rx_bit = d[i];
      step();
    end
    chk("restart_nodone2", 16'(rx_done), 16'd0);
    rx_bit = 1'b0;
    step();
    rx_bit_valid = 1'b0;
    chk("restart_done", 16'(rx_done), 16'(CHK));
    chk("restart_err", 16'(rx_par_err), 16'd0);
    step();

    // Reset mid-frame aborts without rx_done
    capture(9'h1C3, 4'd8, 2'b01, "pre_rst");
    rx_start = 1'b1;
    step();
    rx_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_bit_valid = 1'b1; rx_bit = 1'b1;
      step();
    end
    RST = 1'b0;
    #1;
    chk("midrst_lat", 16'(data_latched), 16'd0);
    chk("midrst_par", 16'(parity), 16'd0);
    chk("midrst_pv", 16'(parity_valid), 16'd0);
    step();
    RST = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
    end
    rx_bit_valid = 1'b0;
    step();
    chk("midrst_nodone", 16'(rx_done), 16'd0);
    chk("midrst_err", 16'(rx_par_err), 16'd0);

    // Random checker frames
    for (int k = 0; k < 12; k++) begin
      rx_frame(WIDTH'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 3) != 0), 1'($urandom), "rx_rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
